// File: rtl/des128_round_ctrl.sv
// rtl/des128_round_ctrl.sv - Feistel round sequencer for the 128-bit expanded-DES core
module des128_round_ctrl #(
    parameter int ROUNDS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         decrypt,
    input  logic [127:0] din,
    output logic         ready,
    output logic         busy,
    output logic [63:0]  f_r,
    output logic [3:0]   key_idx,
    input  logic [63:0]  f_out,
    output logic [127:0] dout,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [3:0] LAST = 4'(ROUNDS - 1);

    state_t      state, state_nx;
    logic [63:0] l_q, r_q;
    logic [3:0]  rnd;
    logic        dec;
    logic        accept;
    logic        last_rnd;

    assign f_r      = r_q;
    assign last_rnd = (rnd == LAST);

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        key_idx  = 4'd0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = ROUND;
                end
            end
            ROUND: begin
                busy    = 1'b1;
                key_idx = dec ? (LAST - rnd) : rnd;
                if (last_rnd) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                ready    = 1'b1;
                done     = 1'b1;
                accept   = start;
                state_nx = start ? ROUND : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The last round writes its result straight into dout with the halves swapped.
    always_ff @(posedge clk) begin
        if (rst) begin
            l_q  <= 64'd0;
            r_q  <= 64'd0;
            rnd  <= 4'd0;
            dec  <= 1'b0;
            dout <= 128'd0;
        end else if (accept) begin
            l_q <= din[127:64];
            r_q <= din[63:0];
            rnd <= 4'd0;
            dec <= decrypt;
        end else if (state == ROUND) begin
            l_q <= r_q;
            r_q <= l_q ^ f_out;
            rnd <= last_rnd ? 4'd0 : rnd + 4'd1;
            if (last_rnd) begin
                dout <= {l_q ^ f_out, r_q};
            end
        end
    end

endmodule
